// File: rtl/automaton_generator.sv
// automaton_generator: sequences a 1-D cellular automaton, writing one
// generation per row into a frame buffer. A run fills ROWS rows back to back,
// then either finishes or keeps appending one row per step tick (scroll mode),
// with top_row tracking the oldest visible row.
module automaton_generator #(
    parameter int unsigned WIDTH = 80,
    parameter int unsigned ROWS  = 60,
    parameter int unsigned AW    = 6
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [WIDTH-1:0] seed,
    input  logic [7:0]       rule_in,
    input  logic             scroll,
    input  logic             step,
    input  logic [WIDTH-1:0] next_in,
    output logic [WIDTH-1:0] cur_out,
    output logic [7:0]       rule_out,
    output logic             wr_en,
    output logic [AW-1:0]    wr_addr,
    output logic [WIDTH-1:0] wr_data,
    output logic [AW-1:0]    top_row,
    output logic             busy,
    output logic             done
);

    localparam logic [AW-1:0] LAST_ROW = AW'(ROWS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_cur;
    logic [7:0]       r_rule;
    logic [AW-1:0]    r_row_ptr;
    logic [AW-1:0]    r_top_row;
    logic             r_wr_en;
    logic [AW-1:0]    r_wr_addr;
    logic [WIDTH-1:0] r_wr_data;
    logic             r_busy;
    logic             r_done;

    state_t           w_state;
    logic [WIDTH-1:0] w_cur;
    logic [7:0]       w_rule;
    logic [AW-1:0]    w_row_ptr;
    logic [AW-1:0]    w_top_row;
    logic             w_wr_en;
    logic [AW-1:0]    w_wr_addr;
    logic [WIDTH-1:0] w_wr_data;
    logic             w_busy;
    logic             w_done;
    logic [AW-1:0]    w_ptr_inc;
    logic             w_ptr_last;

    // Row pointer successor; wraps at ROWS rather than at 2**AW.
    always_comb begin
        w_ptr_last = (r_row_ptr == LAST_ROW);
        w_ptr_inc  = w_ptr_last ? '0 : r_row_ptr + AW'(1);
    end

    // Next-state and next-output logic; every register holds unless overridden.
    always_comb begin
        w_state   = r_state;
        w_cur     = r_cur;
        w_rule    = r_rule;
        w_row_ptr = r_row_ptr;
        w_top_row = r_top_row;
        w_wr_en   = 1'b0;
        w_wr_addr = r_wr_addr;
        w_wr_data = r_wr_data;
        w_done    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_cur     = seed;
                    w_rule    = rule_in;
                    w_row_ptr = '0;
                    w_top_row = '0;
                    w_state   = S_RUN;
                end
            end
            S_RUN: begin
                w_wr_en   = 1'b1;
                w_wr_addr = r_row_ptr;
                w_wr_data = r_cur;
                w_cur     = next_in;
                w_row_ptr = w_ptr_inc;
                if (w_ptr_last) begin
                    w_state = scroll ? S_WAIT : S_DONE;
                end
            end
            S_WAIT: begin
                // Dropping scroll wins over a coincident step: no write.
                if (!scroll) begin
                    w_state = S_DONE;
                end else if (step) begin
                    w_wr_en   = 1'b1;
                    w_wr_addr = r_row_ptr;
                    w_wr_data = r_cur;
                    w_cur     = next_in;
                    w_row_ptr = w_ptr_inc;
                    // Oldest row is the one just after the newest write.
                    w_top_row = w_ptr_inc;
                end
            end
            S_DONE: begin
                w_done  = 1'b1;
                w_state = S_IDLE;
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase

        w_busy = (w_state == S_RUN) || (w_state == S_WAIT);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= S_IDLE;
            r_cur     <= '0;
            r_rule    <= '0;
            r_row_ptr <= '0;
            r_top_row <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_cur     <= w_cur;
            r_rule    <= w_rule;
            r_row_ptr <= w_row_ptr;
            r_top_row <= w_top_row;
            r_wr_en   <= w_wr_en;
            r_wr_addr <= w_wr_addr;
            r_wr_data <= w_wr_data;
            r_busy    <= w_busy;
            r_done    <= w_done;
        end
    end

    assign cur_out  = r_cur;
    assign rule_out = r_rule;
    assign wr_en    = r_wr_en;
    assign wr_addr  = r_wr_addr;
    assign wr_data  = r_wr_data;
    assign top_row  = r_top_row;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule

// File: doc/automaton_generator.md
Name: automaton_generator

Overview:
Sequencing stage that wraps the combinational next-generation logic. It holds the current generation register, drives it into the rule logic, and captures the returned next generation every step. Each generation is written into a row buffer (frame memory) that the VGA scan-out reads. It supports a one-shot fill of ROWS generations and a scrolling mode that appends one generation per external step tick.

Parameters:
WIDTH, 80, cells per generation (row width in bits)
ROWS, 60, generations held in the row buffer
AW, 6, row address width; must satisfy 2**AW >= ROWS

Ports:
clk  in  1  system clock, rising edge
rstn  in  1  asynchronous active-low reset
start  in  1  begin a new run; sampled only in IDLE
seed  in  WIDTH  initial generation, latched on accepted start
rule_in  in  8  Wolfram rule number, latched on accepted start
scroll  in  1  1 = after the fill, continue generating on step; level, sampled each cycle
step  in  1  one-cycle tick (e.g. per vsync) requesting one new generation in scroll mode
next_in  in  WIDTH  next generation from the rule logic (combinational function of cur_out, rule_out)
cur_out  out  WIDTH  current generation register, to the rule logic
rule_out  out  8  latched rule, to the rule logic
wr_en  out  1  row buffer write strobe
wr_addr  out  AW  row buffer write address
wr_data  out  WIDTH  row buffer write data
top_row  out  AW  index of the oldest stored row; display starts here
busy  out  1  high in RUN and WAIT
done  out  1  one-cycle pulse when a run ends

Behaviour:
- Reset (rstn=0, async): state=IDLE. cur_out, rule_out, wr_en, wr_addr, wr_data, top_row, busy, done and row_ptr are all 0. All outputs are registered.
- States: IDLE, RUN, WAIT, DONE.
- IDLE:
  - wr_en=0, busy=0.
  - On start=1: cur<=seed, rule_q<=rule_in, row_ptr<=0, top_row<=0, state<=RUN.
- RUN, every edge:
  - wr_en<=1, wr_addr<=row_ptr, wr_data<=cur.
  - cur<=next_in, row_ptr<=row_ptr+1.
  - If row_ptr==ROWS-1: row_ptr<=0, and state<=WAIT if scroll=1, else state<=DONE.
- Timing: start sampled at edge E0. Row k (generation k, k=0..ROWS-1) is presented with wr_en=1 after edge E(k+1). Row 0 always holds the seed. Writes are back-to-back for ROWS cycles, with no gaps.
- WAIT:
  - wr_en<=0 by default.
  - If scroll=0: state<=DONE. This takes priority over a coincident step, and no write occurs.
  - Else if step=1: perform one RUN-style write at row_ptr and advance cur. Then row_ptr<=(row_ptr==ROWS-1)?0:row_ptr+1, and top_row<=the same wrapped value (the oldest row is the one after the newest).
  - Exactly one write per step pulse. A step held high for N cycles gives N writes.
- DONE: wr_en<=0, done<=1 for exactly one cycle, state<=IDLE. busy is 0 in the cycle done is high.
- start while busy or in DONE: ignored.
- step outside WAIT: ignored.
- rule_in and seed changes after acceptance: ignored until the next accepted start.
- rule_out always equals rule_q. cur_out always equals cur.
- top_row stays 0 for the whole one-shot fill.
- Address arithmetic: row_ptr and top_row wrap at ROWS, not at 2**AW.
- Reset mid-run: immediate return to IDLE with all outputs 0. No partial write completes after rstn falls.

Test Plan:
- Use WIDTH=8, ROWS=4, AW=2, with the real rule logic attached. Cell i's neighbourhood index is {c[i-1], c[i], c[i+1]}, circular.
- One-shot fill: rule_in=90, seed=0x10, scroll=0, start pulse -> writes addr0..3 = 0x10, 0x28, 0x44, 0xAA on 4 consecutive cycles after E1..E4. done pulses once after E5. busy is high for exactly 4 cycles. top_row=0.
- Scroll append: same as above with scroll=1 -> no done after fill, busy stays 1. One step pulse -> single write addr0=0x00 (generation 4), top_row=1. A second step -> addr1=0x00, top_row=2.
- Scroll exit: in WAIT, drive scroll=0 and step=1 in the same cycle -> no write, done pulses next cycle, state returns to IDLE.
- Ignored inputs: during RUN, pulse start and change rule_in to 0 -> write sequence is identical to the one-shot case and rule_out stays 90. A step pulse in IDLE produces no write.
- Reset mid-run: assert rstn=0 after the addr1 write -> all outputs go to 0 asynchronously. After release, a start with rule 204 and seed 0x81 writes 0x81 four times.
